// File: rtl/rr_grant_mux.sv
// Registers the granted port's word into a one-entry valid/ready output stage, acks the port, counts service.
// Latency: one cycle grant-to-out_valid_o; captures only when the stage is empty or draining, so stalls upstream via ack_o.
module rr_grant_mux #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int IDX_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS-1:0]            gnt_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
   output logic [NUM_PORTS-1:0]            ack_o,
   output logic                            out_valid_o,
   output logic [DATA_WIDTH-1:0]           out_data_o,
   output logic [IDX_WIDTH-1:0]            out_port_o,
   input  logic                            out_ready_i,
   output logic                            gnt_err_o,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]  svc_cnt_o
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDX_WIDTH-1:0]  port_q, port_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_PORTS];
   logic [CNT_WIDTH-1:0]  cnt_d [NUM_PORTS];

   logic                  legal, multi, hit, space, capture;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [IDX_WIDTH-1:0]  sel_idx;

   always_comb begin
      sel_data = '0;
      sel_idx  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_i[p]) begin
            sel_data = data_i[p*DATA_WIDTH +: DATA_WIDTH];
            sel_idx  = IDX_WIDTH'(p);
         end
      end
   end

   // A grant whose request has already dropped is arbiter lag, not an error.
   always_comb begin
      legal   = ($countones(gnt_i) == 1);
      multi   = ($countones(gnt_i) > 1);
      hit     = legal && ((gnt_i & req_i) != '0);
      space   = (state_q == EMPTY) || out_ready_i;
      capture = hit && space && !reset;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      port_d  = port_q;
      err_d   = err_q | multi;
      case (state_q)
         EMPTY: if (capture) state_d = FULL;
         FULL:  if (out_ready_i && !capture) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (capture) begin
         data_d = sel_data;
         port_d = sel_idx;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         cnt_d[p] = cnt_q[p];
         if (capture && gnt_i[p] && (cnt_q[p] != '1))
            cnt_d[p] = cnt_q[p] + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         port_q  <= '0;
         err_q   <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         port_q  <= port_d;
         err_q   <= err_d;
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
      end
   end

   assign ack_o       = capture ? gnt_i : '0;
   assign out_valid_o = (state_q == FULL);
   assign out_data_o  = data_q;
   assign out_port_o  = port_q;
   assign gnt_err_o   = err_q;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
      assign svc_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
   end

endmodule
